// File: rtl/step_controller.sv
// -----------------------------------------------------------------------------
// step_controller
//
// Turns the divided clock from the clock divider into single-cycle CPU
// clock-enable pulses in the clk_in domain, gated by a run / pause /
// single-step mode FSM driven by two debounced front-panel buttons and the
// CPU halt line.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable clk_in cycles needed to accept a
//                    new button level (>= 1)
//
// Ports:
//   clk_in    in   system clock, the only clock in the block
//   rst       in   asynchronous active-low reset
//   slow_clk  in   divided clock, sampled as asynchronous data
//   btn_run   in   raw run/pause toggle button, active-high, asynchronous
//   btn_step  in   raw single-step button, active-high, asynchronous
//   halt      in   synchronous CPU halt request, level-sensitive
//   cpu_en    out  registered one-cycle CPU clock enable
//   running   out  registered, high while the FSM is in RUN
//   en_count  out  32-bit count of issued cpu_en pulses (optional)
//
// Build option:
//   STEP_CTRL_EN_COUNT_EN  when defined, adds the en_count port and its
//                          wrapping pulse counter.
// -----------------------------------------------------------------------------
module step_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        slow_clk,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        halt,
  output logic        cpu_en,
  output logic        running
`ifdef STEP_CTRL_EN_COUNT_EN
  ,
  output logic [31:0] en_count
`endif
);

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ARMED  = 2'd2
  } state_t;

  localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

  // Button index 0 is run, index 1 is step.
  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;

  logic        slow_sync1, slow_sync2, slow_sync3;
  logic        slow_tick;
  logic [1:0]  btn_raw;
  logic [1:0]  btn_sync1, btn_sync2;
  logic [1:0]  db_level;
  logic [1:0]  press;
  logic [31:0] db_cnt [2];
  logic        run_press, step_press;

  state_t      state, state_next;
  logic        cpu_en_next;

  assign btn_raw    = {btn_step, btn_run};
  assign run_press  = press[BTN_RUN];
  assign step_press = press[BTN_STEP];

  // sync3 is only a history flop; the tick is the rising edge seen at sync2.
  assign slow_tick = slow_sync2 & ~slow_sync3;

  // NOTE: every flop below is written with <= so all of them sample the
  // values from before the clock edge; a blocking = here would let a later
  // stage see the new value of an earlier one and collapse the synchroniser.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      slow_sync1 <= 1'b0;
      slow_sync2 <= 1'b0;
      slow_sync3 <= 1'b0;
      btn_sync1  <= 2'b00;
      btn_sync2  <= 2'b00;
    end else begin
      slow_sync1 <= slow_clk;
      slow_sync2 <= slow_sync1;
      slow_sync3 <= slow_sync2;
      btn_sync1  <= btn_raw;
      btn_sync2  <= btn_sync1;
    end
  end

  // Debouncer: the counter runs only while the synced level disagrees with
  // the accepted level, so any bounce back to the old level restarts it.
  // The press pulse is registered alongside the level flip, so it is high
  // exactly in the first cycle the new level is visible.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      db_level <= 2'b00;
      press    <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (btn_sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= btn_sync2[i];
          db_cnt[i]   <= '0;
          press[i]    <= btn_sync2[i];   // only 0->1 flips make a pulse
        end else begin
          db_cnt[i] <= db_cnt[i] + 32'd1;
        end
      end
    end
  end

  // NOTE: state_next and cpu_en_next get defaults before the case so every
  // path assigns them; leaving one unassigned would infer a latch.
  always_comb begin
    state_next  = state;
    cpu_en_next = 1'b0;
    case (state)
      PAUSED: begin
        // With halt high a simultaneous run press cannot start RUN, so the
        // step press falls through and arms a single step instead.
        if (run_press && !halt)  state_next = RUN;
        else if (step_press)     state_next = ARMED;
      end
      RUN: begin
        if (halt || run_press) begin
          state_next = PAUSED;   // a coinciding tick is dropped
        end else if (slow_tick) begin
          cpu_en_next = 1'b1;
        end
      end
      ARMED: begin
        // A pending step is honoured even while halted.
        if (slow_tick) begin
          cpu_en_next = 1'b1;
          state_next  = PAUSED;
        end else if (run_press && !halt) begin
          state_next = RUN;
        end
      end
      default: state_next = PAUSED;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state   <= PAUSED;
      cpu_en  <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      cpu_en  <= cpu_en_next;
      running <= (state_next == RUN);
    end
  end

`ifdef STEP_CTRL_EN_COUNT_EN
  // Free-running pulse counter; wraps naturally at 32 bits.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      en_count <= '0;
    end else begin
      en_count <= en_count + {31'd0, cpu_en};
    end
  end
`endif

endmodule

// File: tb/tb_step_controller.sv
// -----------------------------------------------------------------------------
// tb_step_controller
//
// Directed bench for step_controller with DEBOUNCE_CYCLES = 4 and a slow_clk
// period of 20 clk_in cycles. A background monitor counts cpu_en pulses,
// double-wide pulses, pulses whose latency from the slow_clk rise is not
// 3 clk_in edges, and entries into the ARMED state.
// -----------------------------------------------------------------------------
module tb_step_controller;

  localparam int DB = 4;

  logic clk_in   = 1'b0;
  logic rst      = 1'b0;
  logic slow_clk = 1'b0;
  logic btn_run  = 1'b0;
  logic btn_step = 1'b0;
  logic halt     = 1'b0;
  logic cpu_en;
  logic running;
`ifdef STEP_CTRL_EN_COUNT_EN
  logic [31:0] en_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // monitor state
  int         cyc           = 0;
  int         rise_cyc      = -100;
  int         pulse_count   = 0;
  int         width_err     = 0;
  int         lat_err       = 0;
  int         armed_entries = 0;
  logic       prev_en       = 1'b0;
  logic [1:0] prev_state    = 2'd0;

  // slow_clk generator
  bit slow_run = 1'b0;
  int slow_ph  = 0;

  step_controller #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .slow_clk (slow_clk),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .halt     (halt),
    .cpu_en   (cpu_en),
    .running  (running)
`ifdef STEP_CTRL_EN_COUNT_EN
    ,
    .en_count (en_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  // 20-cycle slow clock, high for phases 10..19, changed on falling edges.
  always @(negedge clk_in) begin
    if (!slow_run) begin
      slow_ph  = 0;
      slow_clk = 1'b0;
    end else begin
      slow_ph = (slow_ph == 19) ? 0 : slow_ph + 1;
      if (slow_ph == 10) begin
        slow_clk = 1'b1;
        rise_cyc = cyc;
      end else if (slow_ph == 0) begin
        slow_clk = 1'b0;
      end
    end
  end

  // Monitor samples 1 time unit after each rising edge.
  always @(posedge clk_in) begin
    #1;
    cyc++;
    if (cpu_en === 1'b1) begin
      pulse_count++;
      if (prev_en) width_err++;
      if (cyc - rise_cyc != 3) lat_err++;
    end
    prev_en = cpu_en;
    if (dut.state == 2'd2 && prev_state != 2'd2) armed_entries++;
    prev_state = dut.state;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (observed running, required finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic clear_mon();
    pulse_count   = 0;
    width_err     = 0;
    lat_err       = 0;
    armed_entries = 0;
  endtask

  initial begin
    bit found;

    // ---------------- power-on reset ----------------
    rst = 1'b0;
    wait_cycles(3);
    check("por_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("por_running", {31'd0, running}, 32'd0);
`ifdef STEP_CTRL_EN_COUNT_EN
    check("por_en_count", en_count, 32'd0);
`endif
    rst = 1'b1;
    slow_run = 1'b1;
    clear_mon();
    wait_cycles(60);
    check("idle_pulses", pulse_count, 32'd0);
    check("idle_running", {31'd0, running}, 32'd0);

    // ---------------- run ----------------
    btn_run = 1'b1;
    wait_cycles(6);
    check("run_early", {31'd0, running}, 32'd0);
    wait_cycles(1);
    check("run_on", {31'd0, running}, 32'd1);
    wait_cycles(3);
    btn_run = 1'b0;
    clear_mon();
    wait_cycles(100);
    check("run_pulses", pulse_count, 32'd5);
    check("run_width", width_err, 32'd0);
    check("run_latency", lat_err, 32'd0);
    check("run_still", {31'd0, running}, 32'd1);

    // ---------------- reset mid-run ----------------
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_in);
      if (cpu_en === 1'b1) found = 1'b1;
    end
    check("rst_wait_pulse", {31'd0, found}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
`ifdef STEP_CTRL_EN_COUNT_EN
    check("rst_en_count", en_count, 32'd0);
`endif
    wait_cycles(3);
    rst = 1'b1;
    clear_mon();
    wait_cycles(60);
    check("post_rst_pulses", pulse_count, 32'd0);
    check("post_rst_running", {31'd0, running}, 32'd0);

    // ---------------- bounce ----------------
    clear_mon();
    for (int i = 0; i < 12; i++) begin
      btn_step = ((i / 2) % 2 == 0);
      wait_cycles(1);
    end
    btn_step = 1'b1;
    wait_cycles(10);
    btn_step = 1'b0;
    wait_cycles(40);
    check("bounce_armed", armed_entries, 32'd1);
    check("bounce_pulses", pulse_count, 32'd1);
    check("bounce_width", width_err, 32'd0);
    check("bounce_state", {30'd0, dut.state}, 32'd0);

    // ---------------- halt ----------------
    btn_run = 1'b1;
    wait_cycles(10);
    btn_run = 1'b0;
    wait_cycles(20);
    check("halt_setup_running", {31'd0, running}, 32'd1);
    @(posedge slow_clk);
    clear_mon();
    @(negedge clk_in);
    @(negedge clk_in);
    halt = 1'b1;                 // high during the slow_tick cycle
    @(negedge clk_in);
    check("halt_tick_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("halt_tick_running", {31'd0, running}, 32'd0);
    wait_cycles(25);
    check("halt_pulses", pulse_count, 32'd0);

    clear_mon();
    btn_run = 1'b1;
    wait_cycles(8);
    check("halt_run_running", {31'd0, running}, 32'd0);
    wait_cycles(2);
    btn_run = 1'b0;
    wait_cycles(20);
    check("halt_run_state", {30'd0, dut.state}, 32'd0);
    check("halt_run_pulses", pulse_count, 32'd0);

    clear_mon();
    btn_step = 1'b1;
    wait_cycles(10);
    btn_step = 1'b0;
    wait_cycles(40);
    check("halt_step_pulses", pulse_count, 32'd1);
    check("halt_step_state", {30'd0, dut.state}, 32'd0);
    halt = 1'b0;

    // ---------------- simultaneous presses ----------------
    clear_mon();
    btn_run  = 1'b1;
    btn_step = 1'b1;
    wait_cycles(7);
    check("simul_running", {31'd0, running}, 32'd1);
    check("simul_armed", armed_entries, 32'd0);
    wait_cycles(3);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    wait_cycles(20);
    btn_run = 1'b1;
    wait_cycles(10);
    btn_run = 1'b0;
    wait_cycles(20);
    check("simul_exit", {31'd0, running}, 32'd0);

    halt = 1'b1;
    clear_mon();
    btn_run  = 1'b1;
    btn_step = 1'b1;
    wait_cycles(10);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    wait_cycles(40);
    check("simul_halt_armed", armed_entries, 32'd1);
    check("simul_halt_pulses", pulse_count, 32'd1);
    check("simul_halt_state", {30'd0, dut.state}, 32'd0);
    check("simul_halt_running", {31'd0, running}, 32'd0);
    halt = 1'b0;

`ifdef STEP_CTRL_EN_COUNT_EN
    // ---------------- pulse counter ----------------
    rst = 1'b0;
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(5);
    for (int i = 0; i < 3; i++) begin
      btn_step = 1'b1;
      wait_cycles(10);
      btn_step = 1'b0;
      wait_cycles(40);
    end
    check("cnt_steps", en_count, 32'd3);
    // RUN is active for exactly 40 rising edges before halt stops it.
    btn_run = 1'b1;
    wait_cycles(10);
    btn_run = 1'b0;
    wait_cycles(37);
    halt = 1'b1;
    wait_cycles(3);
    check("cnt_run", en_count, 32'd5);
    halt = 1'b0;
    wait_cycles(20);
    force dut.en_count = 32'hFFFF_FFFF;
    wait_cycles(1);
    release dut.en_count;
    wait_cycles(1);
    check("cnt_forced", en_count, 32'hFFFF_FFFF);
    btn_step = 1'b1;
    wait_cycles(10);
    btn_step = 1'b0;
    wait_cycles(40);
    check("cnt_wrap", en_count, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
